// File: rtl/iic_trans_seq.sv
// Sequences one I2C transaction (register write, or register-pointer write then repeated-start read) as byte ops to a bus engine.
// Latency: one op per phy_done. done pulses in the cycle after the STOP op completes, with the return to IDLE.
// Backpressure: cmd_ready is high only in IDLE. Each op is held on phy_req until the engine returns phy_done.
module iic_trans_seq #(
    parameter int REG_BYTES = 1,
    parameter int LEN_W     = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_rw,
    input  logic [6:0]             cmd_chip,
    input  logic [8*REG_BYTES-1:0] cmd_reg,
    input  logic [LEN_W-1:0]       cmd_len,
    input  logic [7:0]             wr_data,
    output logic                   wr_ready,
    output logic [7:0]             rd_data,
    output logic                   rd_valid,
    output logic                   busy,
    output logic                   done,
    output logic                   err_nack,
    output logic                   phy_req,
    output logic [2:0]             phy_op,
    output logic [7:0]             phy_wdata,
    input  logic                   phy_done,
    input  logic                   phy_ack_in,
    input  logic [7:0]             phy_rdata
);
    // Counter must hold both the register-byte index and the full data length without wrapping.
    localparam int CNT_W = (LEN_W > 2) ? LEN_W : 2;
    localparam logic [CNT_W-1:0] REG_LAST = CNT_W'(REG_BYTES - 1);

    localparam logic [2:0] OP_NONE   = 3'b000;
    localparam logic [2:0] OP_START  = 3'b001;
    localparam logic [2:0] OP_STOP   = 3'b010;
    localparam logic [2:0] OP_WRITE  = 3'b011;
    localparam logic [2:0] OP_RD_ACK = 3'b100;
    localparam logic [2:0] OP_RD_NAK = 3'b101;

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_CHIP_W, S_REG, S_RSTART, S_CHIP_R, S_DATA_W, S_DATA_R, S_STOP
    } state_t;

    state_t                   state_q;
    logic                     rw_q;
    logic [6:0]               chip_q;
    logic [8*REG_BYTES-1:0]   reg_q;
    logic [LEN_W-1:0]         len_q;
    logic [CNT_W-1:0]         byte_cnt_q;
    logic                     err_q;
    logic                     done_q;
    logic                     wr_ready_q;
    logic                     rd_valid_q;
    logic [7:0]               rd_data_q;
    logic [7:0]               reg_byte;
    logic                     last_data;
    logic                     nack_hit;

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign phy_req   = (state_q != S_IDLE) & ~phy_done;
    assign done      = done_q;
    assign err_nack  = err_q;
    assign wr_ready  = wr_ready_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign last_data = (byte_cnt_q == CNT_W'(len_q));
    // Only ops that put a byte on the bus carry a meaningful slave ACK.
    assign nack_hit  = phy_ack_in & ((state_q == S_CHIP_W) | (state_q == S_REG) |
                                     (state_q == S_CHIP_R) | (state_q == S_DATA_W));

    // Pick the register-address byte for this step, most significant byte first.
    always_comb begin
        reg_byte = 8'h00;
        for (int i = 0; i < REG_BYTES; i++) begin
            if (byte_cnt_q == CNT_W'(REG_BYTES - 1 - i)) begin
                reg_byte = reg_q[8*i +: 8];
            end
        end
    end

    // Map the current state onto the bus-engine op and its write byte.
    always_comb begin
        phy_op    = OP_NONE;
        phy_wdata = 8'h00;
        case (state_q)
            S_START, S_RSTART: phy_op = OP_START;
            S_CHIP_W: begin phy_op = OP_WRITE; phy_wdata = {chip_q, 1'b0}; end
            S_REG:    begin phy_op = OP_WRITE; phy_wdata = reg_byte;       end
            S_CHIP_R: begin phy_op = OP_WRITE; phy_wdata = {chip_q, 1'b1}; end
            S_DATA_W: begin phy_op = OP_WRITE; phy_wdata = wr_data;        end
            S_DATA_R: phy_op = last_data ? OP_RD_NAK : OP_RD_ACK;
            S_STOP:   phy_op = OP_STOP;
            default:  phy_op = OP_NONE;
        endcase
    end

    // Transaction FSM: capture the command, step one op per phy_done, abort to STOP on NACK.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            rw_q       <= 1'b0;
            chip_q     <= '0;
            reg_q      <= '0;
            len_q      <= '0;
            byte_cnt_q <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            wr_ready_q <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 8'h00;
        end else begin
            done_q     <= 1'b0;
            wr_ready_q <= 1'b0;
            rd_valid_q <= 1'b0;
            if (state_q == S_IDLE) begin
                if (cmd_valid) begin
                    rw_q    <= cmd_rw;
                    chip_q  <= cmd_chip;
                    reg_q   <= cmd_reg;
                    len_q   <= cmd_len;
                    err_q   <= 1'b0;
                    state_q <= S_START;
                end
            end else if (phy_done) begin
                // A NACKed data byte still consumed the upstream byte.
                if (state_q == S_DATA_W) begin
                    wr_ready_q <= 1'b1;
                end
                if (nack_hit) begin
                    err_q   <= 1'b1;
                    state_q <= S_STOP;
                end else begin
                    case (state_q)
                        S_START:  state_q <= S_CHIP_W;
                        S_CHIP_W: begin state_q <= S_REG; byte_cnt_q <= '0; end
                        S_REG: begin
                            if (byte_cnt_q == REG_LAST) begin
                                byte_cnt_q <= '0;
                                state_q    <= rw_q ? S_RSTART : S_DATA_W;
                            end else begin
                                byte_cnt_q <= byte_cnt_q + 1'b1;
                            end
                        end
                        S_RSTART: state_q <= S_CHIP_R;
                        S_CHIP_R: begin state_q <= S_DATA_R; byte_cnt_q <= '0; end
                        S_DATA_W: begin
                            if (last_data) state_q <= S_STOP;
                            else           byte_cnt_q <= byte_cnt_q + 1'b1;
                        end
                        S_DATA_R: begin
                            rd_data_q  <= phy_rdata;
                            rd_valid_q <= 1'b1;
                            if (last_data) state_q <= S_STOP;
                            else           byte_cnt_q <= byte_cnt_q + 1'b1;
                        end
                        S_STOP: begin
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end
                        default: state_q <= S_IDLE;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_iic_trans_seq.sv
// Bench for iic_trans_seq: a bus-engine model answers ops and checks them against a queue of expected ops.
module tb_iic_trans_seq;
    localparam logic [2:0] OP_NONE = 3'd0, OP_START = 3'd1, OP_STOP = 3'd2, OP_WR = 3'd3,
                           OP_RACK = 3'd4, OP_RNACK = 3'd5;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] dat;
        logic       wd;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rstn;

    logic       cmd_valid, cmd_ready, cmd_rw;
    logic [6:0] cmd_chip;
    logic [7:0] cmd_reg;
    logic [3:0] cmd_len;
    logic [7:0] wr_data, rd_data, phy_wdata, phy_rdata;
    logic       wr_ready, rd_valid, busy, done, err_nack, phy_req, phy_done, phy_ack_in;
    logic [2:0] phy_op;

    logic        cmd_valid2, cmd_ready2, cmd_rw2;
    logic [6:0]  cmd_chip2;
    logic [15:0] cmd_reg2;
    logic [3:0]  cmd_len2;
    logic [7:0]  wr_data2, rd_data2, phy_wdata2, phy_rdata2;
    logic        wr_ready2, rd_valid2, busy2, done2, err_nack2, phy_req2, phy_done2, phy_ack_in2;
    logic [2:0]  phy_op2;

    iic_trans_seq #(.REG_BYTES(1), .LEN_W(4)) dut (
        .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_chip(cmd_chip), .cmd_reg(cmd_reg), .cmd_len(cmd_len), .wr_data(wr_data),
        .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done),
        .err_nack(err_nack), .phy_req(phy_req), .phy_op(phy_op), .phy_wdata(phy_wdata),
        .phy_done(phy_done), .phy_ack_in(phy_ack_in), .phy_rdata(phy_rdata)
    );

    iic_trans_seq #(.REG_BYTES(2), .LEN_W(4)) dut2 (
        .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2), .cmd_rw(cmd_rw2),
        .cmd_chip(cmd_chip2), .cmd_reg(cmd_reg2), .cmd_len(cmd_len2), .wr_data(wr_data2),
        .wr_ready(wr_ready2), .rd_data(rd_data2), .rd_valid(rd_valid2), .busy(busy2), .done(done2),
        .err_nack(err_nack2), .phy_req(phy_req2), .phy_op(phy_op2), .phy_wdata(phy_wdata2),
        .phy_done(phy_done2), .phy_ack_in(phy_ack_in2), .phy_rdata(phy_rdata2)
    );

    int n_cmp = 0;
    int n_fail = 0;
    exp_t       exp_q[$];
    logic [7:0] wr_q[$];
    logic [7:0] rdsrc_q[$];
    logic [7:0] rdexp_q[$];
    logic [7:0] rd_exp_v;
    int   op_idx = 0;
    int   nack_idx = -1;
    logic stray_done = 1'b0;
    int   done_cnt = 0;
    int   wrr_cnt = 0;
    logic last_err = 1'b0;
    logic last_rdy = 1'b0;

    function automatic exp_t mk(input logic [2:0] op, input logic [7:0] dat, input logic wd);
        exp_t e;
        e.op = op; e.dat = dat; e.wd = wd;
        return e;
    endfunction

    // Bus-engine model: completes each op two cycles after it appears and checks it against the queue.
    initial begin : phy_model
        exp_t e;
        int   wait_cnt;
        wait_cnt = 0;
        phy_done = 1'b0; phy_ack_in = 1'b0; phy_rdata = 8'h00;
        forever begin
            @(negedge clk);
            phy_done = 1'b0;
            phy_ack_in = 1'b0;
            if (rstn && busy) begin
                wait_cnt++;
                if (wait_cnt >= 2) begin
                    wait_cnt = 0;
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL op_seq: got op %0d wdata %h, required no op", phy_op, phy_wdata);
                    end else begin
                        e = exp_q.pop_front();
                        if (phy_op !== e.op || (e.op == OP_WR && phy_wdata !== e.dat)) begin
                            n_fail++;
                            $display("FAIL op_seq[%0d]: got op %0d wdata %h, required op %0d wdata %h",
                                     op_idx, phy_op, phy_wdata, e.op, e.dat);
                        end
                        if (e.wd) begin
                            if (wr_q.size() > 0) void'(wr_q.pop_front());
                            wr_data = (wr_q.size() > 0) ? wr_q[0] : 8'h00;
                        end
                    end
                    if (phy_op == OP_RACK || phy_op == OP_RNACK)
                        phy_rdata = (rdsrc_q.size() > 0) ? rdsrc_q.pop_front() : 8'h00;
                    phy_ack_in = (op_idx == nack_idx);
                    op_idx++;
                    phy_done = 1'b1;
                end
            end else begin
                wait_cnt = 0;
                phy_done = stray_done;
                phy_ack_in = stray_done;
            end
        end
    end

    // Output monitor: counts pulses and checks read bytes against the expected queue.
    always @(negedge clk) begin
        if (wr_ready) wrr_cnt++;
        if (done) begin
            done_cnt++;
            last_err = err_nack;
            last_rdy = cmd_ready;
        end
        if (rd_valid) begin
            n_cmp++;
            if (rdexp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rd_seq: got %h, required no read byte", rd_data);
            end else begin
                rd_exp_v = rdexp_q.pop_front();
                if (rd_data !== rd_exp_v) begin
                    n_fail++;
                    $display("FAIL rd_seq: got %h, required %h", rd_data, rd_exp_v);
                end
            end
        end
    end

    task automatic issue(input logic rw, input logic [6:0] chip, input logic [7:0] rg, input logic [3:0] len);
        @(negedge clk);
        cmd_rw = rw; cmd_chip = chip; cmd_reg = rg; cmd_len = len; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        for (int k = 0; k < budget && done_cnt < target; k++) @(negedge clk);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if ({cmd_ready, busy, done, err_nack} !== 4'b1000) begin
            n_fail++; $display("FAIL reset_ctrl: got %b, required 1000", {cmd_ready, busy, done, err_nack});
        end
        n_cmp++;
        if ({rd_valid, wr_ready, rd_data} !== 10'h000) begin
            n_fail++; $display("FAIL reset_data: got %h, required 000", {rd_valid, wr_ready, rd_data});
        end
        n_cmp++;
        if ({phy_req, phy_op, phy_wdata} !== 12'h000) begin
            n_fail++; $display("FAIL reset_phy: got %h, required 000", {phy_req, phy_op, phy_wdata});
        end
    endtask

    task automatic test_write();
        int d0 = done_cnt, w0 = wrr_cnt;
        op_idx = 0; nack_idx = -1;
        exp_q.push_back(mk(OP_START, 8'h00, 0)); exp_q.push_back(mk(OP_WR, 8'hA0, 0));
        exp_q.push_back(mk(OP_WR, 8'h12, 0));    exp_q.push_back(mk(OP_WR, 8'hA5, 1));
        exp_q.push_back(mk(OP_STOP, 8'h00, 0));
        wr_q.push_back(8'hA5); wr_data = 8'hA5;
        issue(1'b0, 7'h50, 8'h12, 4'd0);
        wait_done(d0 + 1, 200);
        n_cmp++;
        if (done_cnt !== d0 + 1 || last_err !== 1'b0) begin
            n_fail++; $display("FAIL write_done: got done %0d err %b, required 1 err 0", done_cnt - d0, last_err);
        end
        n_cmp++;
        if (wrr_cnt - w0 !== 1 || exp_q.size() !== 0) begin
            n_fail++; $display("FAIL write_ops: got wr_ready %0d left %0d, required 1 left 0", wrr_cnt - w0, exp_q.size());
        end
    endtask

    task automatic test_read(input logic [6:0] chip, input logic [7:0] rg, input int nbytes);
        int d0 = done_cnt;
        logic [7:0] b;
        op_idx = 0; nack_idx = -1;
        exp_q.push_back(mk(OP_START, 8'h00, 0)); exp_q.push_back(mk(OP_WR, {chip, 1'b0}, 0));
        exp_q.push_back(mk(OP_WR, rg, 0));       exp_q.push_back(mk(OP_START, 8'h00, 0));
        exp_q.push_back(mk(OP_WR, {chip, 1'b1}, 0));
        for (int i = 0; i < nbytes; i++) begin
            b = (nbytes == 2) ? ((i == 0) ? 8'h11 : 8'h22) : 8'($urandom_range(0, 255));
            exp_q.push_back(mk((i == nbytes - 1) ? OP_RNACK : OP_RACK, 8'h00, 0));
            rdsrc_q.push_back(b); rdexp_q.push_back(b);
        end
        exp_q.push_back(mk(OP_STOP, 8'h00, 0));
        issue(1'b1, chip, rg, 4'(nbytes - 1));
        wait_done(d0 + 1, 400);
        n_cmp++;
        if (done_cnt !== d0 + 1 || last_err !== 1'b0 || exp_q.size() !== 0 || rdexp_q.size() !== 0) begin
            n_fail++; $display("FAIL read_%0d: got done %0d err %b ops left %0d rd left %0d, required 1 0 0 0",
                               nbytes, done_cnt - d0, last_err, exp_q.size(), rdexp_q.size());
        end
    endtask

    task automatic test_nack_chip();
        int d0 = done_cnt, w0 = wrr_cnt;
        op_idx = 0; nack_idx = 1;
        exp_q.push_back(mk(OP_START, 8'h00, 0)); exp_q.push_back(mk(OP_WR, 8'hA0, 0));
        exp_q.push_back(mk(OP_STOP, 8'h00, 0));
        issue(1'b0, 7'h50, 8'h12, 4'd0);
        wait_done(d0 + 1, 200);
        n_cmp++;
        if (done_cnt !== d0 + 1 || last_err !== 1'b1 || exp_q.size() !== 0 || wrr_cnt !== w0) begin
            n_fail++; $display("FAIL nack_chip: got done %0d err %b left %0d wr_ready %0d, required 1 1 0 0",
                               done_cnt - d0, last_err, exp_q.size(), wrr_cnt - w0);
        end
        nack_idx = -1;
    endtask

    task automatic test_nack_data();
        int d0 = done_cnt, w0 = wrr_cnt;
        op_idx = 0; nack_idx = 4;
        exp_q.push_back(mk(OP_START, 8'h00, 0)); exp_q.push_back(mk(OP_WR, 8'hA0, 0));
        exp_q.push_back(mk(OP_WR, 8'h40, 0));    exp_q.push_back(mk(OP_WR, 8'h01, 1));
        exp_q.push_back(mk(OP_WR, 8'h02, 1));    exp_q.push_back(mk(OP_STOP, 8'h00, 0));
        wr_q.push_back(8'h01); wr_q.push_back(8'h02); wr_q.push_back(8'h03); wr_data = 8'h01;
        issue(1'b0, 7'h50, 8'h40, 4'd2);
        wait_done(d0 + 1, 200);
        n_cmp++;
        if (done_cnt !== d0 + 1 || last_err !== 1'b1 || exp_q.size() !== 0 || wrr_cnt - w0 !== 2) begin
            n_fail++; $display("FAIL nack_data: got done %0d err %b left %0d wr_ready %0d, required 1 1 0 2",
                               done_cnt - d0, last_err, exp_q.size(), wrr_cnt - w0);
        end
        nack_idx = -1; wr_q.delete();
    endtask

    task automatic test_burst_max();
        int d0 = done_cnt, w0 = wrr_cnt;
        logic [7:0] b;
        op_idx = 0; nack_idx = -1;
        exp_q.push_back(mk(OP_START, 8'h00, 0)); exp_q.push_back(mk(OP_WR, 8'hA0, 0));
        exp_q.push_back(mk(OP_WR, 8'h7E, 0));
        for (int i = 0; i < 16; i++) begin
            b = 8'(i * 17 + 3);
            wr_q.push_back(b); exp_q.push_back(mk(OP_WR, b, 1));
        end
        exp_q.push_back(mk(OP_STOP, 8'h00, 0));
        wr_data = wr_q[0];
        issue(1'b0, 7'h50, 8'h7E, 4'hF);
        wait_done(d0 + 1, 400);
        n_cmp++;
        if (done_cnt !== d0 + 1 || exp_q.size() !== 0 || wrr_cnt - w0 !== 16) begin
            n_fail++; $display("FAIL burst_max: got done %0d left %0d wr_ready %0d, required 1 0 16",
                               done_cnt - d0, exp_q.size(), wrr_cnt - w0);
        end
    endtask

    task automatic test_idle_done();
        int d0 = done_cnt, w0 = wrr_cnt;
        @(negedge clk); stray_done = 1'b1;
        @(negedge clk); @(negedge clk); stray_done = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done_cnt !== d0 || wrr_cnt !== w0 || last_err !== 1'b0) begin
            n_fail++; $display("FAIL idle_done: got busy %b done %0d wr_ready %0d, required 0 0 0",
                               busy, done_cnt - d0, wrr_cnt - w0);
        end
    endtask

    task automatic test_busy_ignore();
        int d0 = done_cnt;
        op_idx = 0; nack_idx = -1;
        exp_q.push_back(mk(OP_START, 8'h00, 0)); exp_q.push_back(mk(OP_WR, 8'hA0, 0));
        exp_q.push_back(mk(OP_WR, 8'h12, 0));    exp_q.push_back(mk(OP_WR, 8'h5C, 1));
        exp_q.push_back(mk(OP_STOP, 8'h00, 0));
        wr_q.push_back(8'h5C); wr_data = 8'h5C;
        issue(1'b0, 7'h50, 8'h12, 4'd0);
        cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_chip = 7'h7F; cmd_len = 4'd5;
        repeat (4) @(negedge clk);
        cmd_valid = 1'b0;
        wait_done(d0 + 1, 200);
        repeat (6) @(negedge clk);
        n_cmp++;
        if (done_cnt !== d0 + 1 || busy !== 1'b0 || exp_q.size() !== 0) begin
            n_fail++; $display("FAIL busy_ignore: got done %0d busy %b left %0d, required 1 0 0",
                               done_cnt - d0, busy, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int d0 = done_cnt, w0 = wrr_cnt;
        int k = 0;
        op_idx = 0; nack_idx = 1;
        exp_q.push_back(mk(OP_START, 8'h00, 0)); exp_q.push_back(mk(OP_WR, 8'hA0, 0));
        exp_q.push_back(mk(OP_STOP, 8'h00, 0));
        exp_q.push_back(mk(OP_START, 8'h00, 0)); exp_q.push_back(mk(OP_WR, 8'hA0, 0));
        exp_q.push_back(mk(OP_WR, 8'h12, 0));    exp_q.push_back(mk(OP_WR, 8'hA5, 1));
        exp_q.push_back(mk(OP_STOP, 8'h00, 0));
        wr_q.push_back(8'hA5); wr_data = 8'hA5;
        @(negedge clk);
        cmd_rw = 1'b0; cmd_chip = 7'h50; cmd_reg = 8'h12; cmd_len = 4'd0; cmd_valid = 1'b1;
        do begin @(negedge clk); k++; end while (done !== 1'b1 && k < 200);
        n_cmp++;
        if (done !== 1'b1 || err_nack !== 1'b1 || cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_first: got done %b err %b ready %b, required 1 1 1", done, err_nack, cmd_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1 || err_nack !== 1'b0) begin
            n_fail++; $display("FAIL b2b_accept: got busy %b err %b, required 1 0", busy, err_nack);
        end
        cmd_valid = 1'b0;
        wait_done(d0 + 2, 200);
        n_cmp++;
        if (done_cnt !== d0 + 2 || last_err !== 1'b0 || last_rdy !== 1'b1 || exp_q.size() !== 0 || wrr_cnt - w0 !== 1) begin
            n_fail++; $display("FAIL b2b_second: got done %0d err %b ready %b left %0d wr_ready %0d, required 2 0 1 0 1",
                               done_cnt - d0, last_err, last_rdy, exp_q.size(), wrr_cnt - w0);
        end
        nack_idx = -1;
    endtask

    task automatic test_reset_mid();
        int d0 = done_cnt;
        int k = 0;
        op_idx = 0; nack_idx = -1;
        exp_q.push_back(mk(OP_START, 8'h00, 0)); exp_q.push_back(mk(OP_WR, 8'hA0, 0));
        exp_q.push_back(mk(OP_WR, 8'h21, 0));
        for (int i = 0; i < 4; i++) begin
            wr_q.push_back(8'(8'hC0 + i)); exp_q.push_back(mk(OP_WR, 8'(8'hC0 + i), 1));
        end
        exp_q.push_back(mk(OP_STOP, 8'h00, 0));
        wr_data = wr_q[0];
        issue(1'b0, 7'h50, 8'h21, 4'd3);
        // wr_ready marks the first cycle of the second data byte
        while (wr_ready !== 1'b1 && k < 200) begin @(negedge clk); k++; end
        rstn = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy, phy_req, cmd_ready, phy_op, done, wr_ready} !== 8'b00100000) begin
            n_fail++; $display("FAIL reset_mid: got %b, required 00100000", {busy, phy_req, cmd_ready, phy_op, done, wr_ready});
        end
        rstn = 1'b1;
        exp_q.delete(); wr_q.delete();
        repeat (5) @(negedge clk);
        n_cmp++;
        if (done_cnt !== d0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_done: got done %0d busy %b, required 0 0", done_cnt - d0, busy);
        end
    endtask

    task automatic test_reg_bytes2();
        exp_t q2[$];
        exp_t e;
        int k;
        q2.push_back(mk(OP_START, 8'h00, 0)); q2.push_back(mk(OP_WR, 8'hA0, 0));
        q2.push_back(mk(OP_WR, 8'hBE, 0));    q2.push_back(mk(OP_WR, 8'hEF, 0));
        q2.push_back(mk(OP_WR, 8'h5A, 0));    q2.push_back(mk(OP_STOP, 8'h00, 0));
        @(negedge clk);
        cmd_rw2 = 1'b0; cmd_chip2 = 7'h50; cmd_reg2 = 16'hBEEF; cmd_len2 = 4'd0; wr_data2 = 8'h5A; cmd_valid2 = 1'b1;
        @(negedge clk);
        cmd_valid2 = 1'b0;
        while (q2.size() > 0) begin
            k = 0;
            do begin @(negedge clk); k++; end while (phy_req2 !== 1'b1 && k < 20);
            e = q2.pop_front();
            n_cmp++;
            if (phy_req2 !== 1'b1 || phy_op2 !== e.op || (e.op == OP_WR && phy_wdata2 !== e.dat)) begin
                n_fail++; $display("FAIL reg2_seq: got req %b op %0d wdata %h, required 1 op %0d wdata %h",
                                   phy_req2, phy_op2, phy_wdata2, e.op, e.dat);
            end
            phy_done2 = 1'b1;
            @(negedge clk);
            phy_done2 = 1'b0;
        end
        n_cmp++;
        if (done2 !== 1'b1 || err_nack2 !== 1'b0 || busy2 !== 1'b0) begin
            n_fail++; $display("FAIL reg2_done: got done %b err %b busy %b, required 1 0 0", done2, err_nack2, busy2);
        end
    endtask

    initial begin
        rstn = 1'b0;
        cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_chip = '0; cmd_reg = '0; cmd_len = '0; wr_data = '0;
        cmd_valid2 = 1'b0; cmd_rw2 = 1'b0; cmd_chip2 = '0; cmd_reg2 = '0; cmd_len2 = '0; wr_data2 = '0;
        phy_done2 = 1'b0; phy_ack_in2 = 1'b0; phy_rdata2 = 8'h00;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        test_reset();
        test_write();
        test_read(7'h50, 8'h34, 2);
        n_cmp++;
        if (rd_data !== 8'h22) begin
            n_fail++; $display("FAIL rd_hold: got %h, required 22", rd_data);
        end
        test_read(7'h3C, 8'h07, 1);
        test_nack_chip();
        test_nack_data();
        test_burst_max();
        test_read(7'h2A, 8'h99, 16);
        test_idle_done();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        test_reg_bytes2();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/iic_trans_seq.md
Name: iic_trans_seq

Overview:
- Parametrised I2C master transaction sequencer; successor to the fixed start/chip/reg/data/stop controller.
- Accepts one command at a time: write or read, 7-bit chip address, multi-byte register address, 1..2^LEN_W data bytes.
- Drives a byte-level bus engine through a req/done handshake.
- Adds repeated-start reads, burst length, slave NACK abort, and a done/error status.

Parameters:
REG_BYTES, 1, register-address bytes (1..4); sent MSB byte first
LEN_W, 4, width of cmd_len; byte count = cmd_len+1

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid&cmd_ready
cmd_rw  in  1  0=write, 1=read
cmd_chip  in  7  slave address
cmd_reg  in  8*REG_BYTES  register address
cmd_len  in  LEN_W  data bytes minus one
wr_data  in  8  write byte; must be stable while phy_req is high in DATA_W
wr_ready  out  1  1-cycle pulse when a write data byte completes
rd_data  out  8  last read byte (registered)
rd_valid  out  1  1-cycle pulse with each new rd_data
busy  out  1  state != IDLE
done  out  1  1-cycle pulse on STOP completion
err_nack  out  1  valid with done; 1 = transaction aborted on NACK
phy_req  out  1  bus-engine request
phy_op  out  3  000 NONE, 001 START, 010 STOP, 011 WRITE, 100 READ_ACK, 101 READ_NACK
phy_wdata  out  8  byte for WRITE ops
phy_done  in  1  1-cycle pulse: current op finished
phy_ack_in  in  1  slave ACK bit sampled on WRITE; 1 = NACK; valid with phy_done
phy_rdata  in  8  read byte, valid with phy_done

Behaviour:
- Reset values: cmd_ready=1, busy=0, done=0, err_nack=0, rd_valid=0, rd_data=0, wr_ready=0, phy_req=0, phy_op=000, phy_wdata=0.
- Command fields are captured into internal registers on acceptance. The state leaves IDLE on the next edge.
- States and phy_op:
  - IDLE: NONE
  - START: START
  - CHIP_W: WRITE {chip,0}
  - REG: WRITE reg byte
  - RSTART: START
  - CHIP_R: WRITE {chip,1}
  - DATA_W: WRITE wr_data
  - DATA_R: READ_ACK, or READ_NACK on the last byte
  - STOP: STOP
- phy_req = (state != IDLE) & ~phy_done, combinational. It drops in the phy_done cycle. The state advances on that edge.
- Write path: START -> CHIP_W -> REG x REG_BYTES -> DATA_W x (len+1) -> STOP -> IDLE.
- Read path: START -> CHIP_W -> REG x REG_BYTES -> RSTART -> CHIP_R -> DATA_R x (len+1) -> STOP -> IDLE.
- byte_cnt:
  - Cleared on entry to REG, DATA_W and DATA_R; increments on each phy_done.
  - REG exits when byte_cnt==REG_BYTES-1. DATA exits when byte_cnt==len_r.
  - REG byte index REG_BYTES-1-byte_cnt, so MSB is sent first.
- NACK: phy_done with phy_ack_in=1 in CHIP_W, REG, CHIP_R or DATA_W goes to STOP and sets the err latch.
- phy_ack_in is ignored for START, STOP and READ ops.
- The err latch is cleared on command acceptance. err_nack reflects the latch and is meaningful with done.
- wr_ready pulses in the cycle after phy_done of a DATA_W byte, including a NACKed byte.
- rd_data is loaded from phy_rdata on phy_done in DATA_R. rd_valid pulses in the following cycle.
- done pulses in the cycle after phy_done of STOP, coincident with returning to IDLE. cmd_ready returns high in that same cycle.
- Boundaries:
  - phy_done while IDLE is ignored.
  - cmd_valid while busy is ignored.
  - cmd_len=0 gives a single byte; a single read byte uses READ_NACK.
  - cmd_len=all-ones gives 2^LEN_W bytes with no counter wrap.
- Reset mid-transaction: next edge IDLE, all outputs at reset values, no done pulse. Recovering the bus is the upstream's responsibility.

Test Plan:
- Write: chip=0x50, reg=0x12, len=0, wr_data=0xA5, all ACK -> phy_op START, WRITE 0xA0, WRITE 0x12, WRITE 0xA5, STOP; one wr_ready; done=1, err_nack=0.
- Read: chip=0x50, reg=0x34, len=1, phy_rdata 0x11 then 0x22 -> START, WRITE 0xA0, WRITE 0x34, START, WRITE 0xA1, READ_ACK, READ_NACK, STOP; rd_valid twice with 0x11, 0x22.
- NACK on chip byte (phy_ack_in=1 with CHIP_W done) -> next op STOP; no REG op; done with err_nack=1.
- REG_BYTES=2, reg=0xBEEF -> REG writes 0xBE then 0xEF.
- rstn low during DATA_W byte 2 of 4 -> next cycle IDLE, phy_req=0, cmd_ready=1, no done.
- Command held valid through done -> new command accepted in the done cycle; no idle gap beyond one cycle; err latch cleared.
